// File: rtl/lfsr_pkg.sv
// Shared defaults and FSM state type for the LFSR run controller.
package lfsr_pkg;

  localparam int          LFSR_WIDTH = 16;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

endpackage

// File: rtl/lfsr_next.sv
// Fibonacci LFSR step: shift left, feedback bit is the parity of the tapped bits.
// Purely combinational; holds no state.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  assign o_next = {i_state[WIDTH-2:0], ^(i_state & TAPS)};

endmodule

// File: rtl/lfsr_ctrl.sv
// Runs an LFSR from a captured seed, streaming each state over valid/ready until
// the state repeats or the step limit is hit; reports the measured period.
module lfsr_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] max_steps,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] period,
  output logic             period_found,
  output logic             err_zero_seed
);

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_period_found;
  logic             r_err_zero;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_count_inc;
  logic             w_accept;
  logic             w_xfer;
  logic             w_hit_seed;
  logic             w_hit_limit;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .i_state (r_lfsr),
    .o_next  (w_next)
  );

  // abort outranks both a start in IDLE and a transfer in RUN
  assign w_accept    = (r_fsm == ST_IDLE) && start && !abort;
  assign w_xfer      = out_valid && out_ready && !abort;
  assign w_count_inc = r_count + 1'b1;
  assign w_hit_seed  = (w_next == r_seed);
  assign w_hit_limit = (w_count_inc == r_limit);

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE: begin
        if (w_accept) begin
          w_fsm_nxt = (seed == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_fsm_nxt = ST_IDLE;
        end else if (w_xfer && (w_hit_seed || w_hit_limit)) begin
          w_fsm_nxt = ST_DONE;
        end
      end
      ST_DONE: w_fsm_nxt = ST_IDLE;
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm          <= ST_IDLE;
      r_lfsr         <= '0;
      r_seed         <= '0;
      r_limit        <= '0;
      r_count        <= '0;
      r_period       <= '0;
      r_period_found <= 1'b0;
      r_err_zero     <= 1'b0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (w_accept) begin
        r_lfsr         <= seed;
        r_seed         <= seed;
        // zero requests the longest possible run, so count can never wrap
        r_limit        <= (max_steps == '0) ? '1 : max_steps;
        r_count        <= '0;
        r_period       <= '0;
        r_period_found <= 1'b0;
        r_err_zero     <= (seed == '0);
      end else if (w_xfer) begin
        r_lfsr  <= w_next;
        r_count <= w_count_inc;
        if (w_hit_seed) begin
          r_period       <= w_count_inc;
          r_period_found <= 1'b1;
        end else if (w_hit_limit) begin
          r_period <= w_count_inc;
        end
      end
    end
  end

  assign out_valid     = (r_fsm == ST_RUN);
  assign busy          = (r_fsm == ST_RUN);
  assign done          = (r_fsm == ST_DONE);
  assign out_data      = r_lfsr;
  assign period        = r_period;
  assign period_found  = r_period_found;
  assign err_zero_seed = r_err_zero;

endmodule
